// File: rtl/wide_add_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer_pkg
// Purpose : shared constants for the wide add/sub sequencer and its word adder.
//           Holds the slice width and the FSM state encoding. The state
//           encoding is also the value seen on the sequencer's debug state
//           port.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package wide_add_sequencer_pkg;

  // Width of one operand slice handled per cycle by the word adder.
  localparam int WORD_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage : wide_add_sequencer_pkg

// File: rtl/wide_add_sequencer_bypass_adder.sv
// -----------------------------------------------------------------------------
// bypass_adder
// Purpose : 32-bit combinational adder slice with carry in/out and a
//           two's-complement overflow flag for that slice.
// Ports   :
//   a_i        in  WORD_W  addend A
//   b_i        in  WORD_W  addend B (already inverted by the caller for subtract)
//   cin_i      in  1       carry in
//   sum_o      out WORD_W  a_i + b_i + cin_i (low WORD_W bits)
//   cout_o     out 1       carry out of the top bit
//   overflow_o out 1       signed overflow of this slice
// -----------------------------------------------------------------------------
module bypass_adder
  import wide_add_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o,
  output logic              overflow_o
);

  logic [WORD_W:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};
  assign sum_o    = full_sum[WORD_W-1:0];
  assign cout_o   = full_sum[WORD_W];

  // Signed overflow: both addends share a sign that the sum does not.
  assign overflow_o = (a_i[WORD_W-1] == b_i[WORD_W-1]) &&
                      (sum_o[WORD_W-1] != a_i[WORD_W-1]);

endmodule : bypass_adder

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
// Purpose : multi-cycle NUM_WORDS*32-bit adder/subtractor. Operands are
//           captured on start, then streamed LSW first through one 32-bit
//           bypass_adder, chaining the carry between cycles.
// Handshake:
//   start is a 1-cycle request sampled only in IDLE; starts arriving in RUN or
//   DONE are dropped, not queued. busy is high while slices are being
//   processed (cycle after accepted start up to the last slice). done pulses
//   for exactly one cycle, NUM_WORDS+1 cycles after the start edge; result,
//   cout and overflow are valid from that cycle and held until the next
//   accepted start. A new start is accepted from the cycle after done.
// Ports   :
//   clk          in  1  rising-edge clock
//   rst_n        in  1  asynchronous active-low reset
//   start        in  1  operation request
//   sub          in  1  0 = a+b, 1 = a-b (captured with start)
//   a_in         in  W  operand A (captured with start)
//   b_in         in  W  operand B (captured with start)
//   busy         out 1  operation in progress
//   done         out 1  1-cycle completion pulse
//   result       out W  sum / difference
//   cout         out 1  carry out of the MSW (subtract: 1 = no borrow)
//   overflow     out 1  signed overflow of the full W-bit operation
//   dbg_state_o  out 2  current FSM state (ST_IDLE/ST_RUN/ST_DONE)
// -----------------------------------------------------------------------------
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sub,
  input  logic [WORD_W*NUM_WORDS-1:0] a_in,
  input  logic [WORD_W*NUM_WORDS-1:0] b_in,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_W*NUM_WORDS-1:0] result,
  output logic                        cout,
  output logic                        overflow,
  output state_t                      dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Operands and result are kept as word arrays so the active slice is a
  // plain index by the word counter.
  state_t                                state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic                                  carry_q, carry_d;
  logic                                  sub_q, sub_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]      a_q, a_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]      b_q, b_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]      result_q, result_d;
  logic                                  cout_q, cout_d;
  logic                                  ovf_q, ovf_d;

  logic [WORD_W-1:0] add_a, add_b, add_sum;
  logic              add_cout, add_ovf;

  // Subtract is a + ~b + 1: the +1 enters as the initial carry loaded at
  // start, the inversion is applied to every B slice here.
  assign add_a = a_q[idx_q];
  assign add_b = b_q[idx_q] ^ {WORD_W{sub_q}};

  bypass_adder u_adder (
    .a_i        (add_a),
    .b_i        (add_b),
    .cin_i      (carry_q),
    .sum_o      (add_sum),
    .cout_o     (add_cout),
    .overflow_o (add_ovf)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        result_d[idx_q] = add_sum;
        carry_d         = add_cout;
        if (idx_q == IDX_LAST) begin
          // Only the MSW slice's overflow describes the full-width operation.
          cout_d  = add_cout;
          ovf_d   = add_ovf;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule : wide_add_sequencer

// File: tb/tb_wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wide_add_sequencer
// Self-checking bench for wide_add_sequencer (NUM_WORDS = 4). Expected
// results are queued when an operation is started and compared when done
// pulses. A vector table covers the main arithmetic cases; hand-written
// sequences cover start-while-busy, result hold and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_wide_add_sequencer;
  import wide_add_sequencer_pkg::*;

  localparam int NW = 4;
  localparam int W  = WORD_W * NW;
  localparam int NUM_VECS = 10;

  // ---------------------------------------------------------------- clock/reset
  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  state_t       dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wide_add_sequencer #(.NUM_WORDS(NW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sub         (sub),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int exp_dones = 0;
  logic [W+1:0] exp_q[$];   // {result, cout, overflow}
  logic [W+1:0] mon_e;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent full-width reference: one W-bit addition.
  function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] bb;
    logic [W:0]   t;
    logic         v;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    v  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return {t[W-1:0], t[W], v};
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < NW; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        mon_e = exp_q.pop_front();
        check("result", result, mon_e[W+1:2]);
        check("cout", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, mon_e[1]});
        check("overflow", {{(W-1){1'b0}}, overflow}, {{(W-1){1'b0}}, mon_e[0]});
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // Called at a negedge. inject > 0 pulses start with unrelated operands in
  // that cycle after the accepted start.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W+1:0] exp, input int inject);
    int n;
    int done_cyc;
    n = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
    end
    start = 1'b1;
    sub   = s;
    a_in  = a;
    b_in  = b;
    exp_q.push_back(exp);
    exp_dones++;
    done_cyc = 0;
    for (int cyc = 1; cyc <= NW + 2; cyc++) begin
      @(negedge clk);
      start = (cyc == inject);
      sub   = ~s;
      a_in  = rand_w();
      b_in  = rand_w();
      if (cyc == 1) begin
        check("busy_after_start", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, 1'b1});
      end
      if (done === 1'b1 && done_cyc == 0) done_cyc = cyc;
      if (cyc == NW + 2) begin
        check("done_one_cycle", {{(W-1){1'b0}}, done}, '0);
      end
    end
    start = 1'b0;
    check("done_latency", W'(done_cyc), W'(NW + 1));
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic         exp_c;
    logic         exp_v;
  } vec_t;

  vec_t vecs[NUM_VECS];

  initial begin
    int snap;
    logic [W+1:0] m;
    logic [W-1:0] ra, rb;

    // 32-bit-carry into slice 1
    vecs[0] = '{1'b0, {{(W-32){1'b0}}, 32'hFFFF_FFFF}, W'(1),
                {{(W-64){1'b0}}, 64'h1_0000_0000}, 1'b0, 1'b0};
    // carry ripples through every slice
    vecs[1] = '{1'b0, {W{1'b1}}, W'(1), '0, 1'b1, 1'b0};
    // positive overflow
    vecs[2] = '{1'b0, {1'b0, {(W-1){1'b1}}}, W'(1), {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1};
    // 5 - 7 = -2 (borrow)
    vecs[3] = '{1'b1, W'(5), W'(7), {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0};
    // 7 - 5 = 2 (no borrow)
    vecs[4] = '{1'b1, W'(7), W'(5), W'(2), 1'b1, 1'b0};
    // most negative minus one overflows
    vecs[5] = '{1'b1, {1'b1, {(W-1){1'b0}}}, W'(1), {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1};
    for (int i = 6; i < NUM_VECS; i++) begin
      ra = rand_w();
      rb = rand_w();
      m  = model(i[0], ra, rb);
      vecs[i] = '{i[0], ra, rb, m[W+1:2], m[1], m[0]};
    end

    // reset
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {{(W-1){1'b0}}, busy}, '0);
    check("rst_done", {{(W-1){1'b0}}, done}, '0);
    check("rst_result", result, '0);
    check("rst_cout", {{(W-1){1'b0}}, cout}, '0);
    check("rst_overflow", {{(W-1){1'b0}}, overflow}, '0);
    check("rst_state", W'(dbg_state), W'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // table
    for (int i = 0; i < NUM_VECS; i++) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, {vecs[i].exp_r, vecs[i].exp_c, vecs[i].exp_v}, 0);
    end

    // result held after done
    repeat (3) @(negedge clk);
    check("result_hold", result, vecs[NUM_VECS-1].exp_r);

    // start during RUN and during DONE is ignored
    ra = rand_w();
    rb = rand_w();
    do_op(1'b0, ra, rb, model(1'b0, ra, rb), 2);
    ra = rand_w();
    rb = rand_w();
    do_op(1'b1, ra, rb, model(1'b1, ra, rb), NW + 1);
    repeat (NW + 3) @(negedge clk);
    check("done_count_ignored_start", W'(done_count), W'(exp_dones));

    // reset while the word counter is at slice 2
    snap  = done_count;
    start = 1'b1;
    sub   = 1'b0;
    a_in  = rand_w();
    b_in  = rand_w();
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("run_before_abort", W'(dbg_state), W'(ST_RUN));
    rst_n = 1'b0;
    #1;
    check("abort_busy", {{(W-1){1'b0}}, busy}, '0);
    check("abort_done", {{(W-1){1'b0}}, done}, '0);
    check("abort_result", result, '0);
    check("abort_cout", {{(W-1){1'b0}}, cout}, '0);
    check("abort_overflow", {{(W-1){1'b0}}, overflow}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (NW + 3) @(negedge clk);
    check("abort_no_done", W'(done_count), W'(snap));
    do_op(1'b0, W'(3), W'(4), {W'(7), 1'b0, 1'b0}, 0);

    repeat (2) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), '0);
    check("total_dones", W'(done_count), W'(exp_dones));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wide_add_sequencer
